list_sum_datapath: RTL

Datapath for the linked-list summation unit, directly downstream of the list-sum control FSM. It consumes the FSM's registered controls (`LOAD_SUM`, `LOAD_NEXT`, `SUM_SEL`, `NEXT_SEL`, `ADDR_SEL`, `DONE`) and returns `next_zero`. It owns the node memory, the running-sum and next-pointer registers, and a host preload port, and it publishes a latched result.

---
 rtl/list_sum_datapath_pkg.sv | 18 +
 rtl/list_sum_datapath_if.sv | 24 ++
 rtl/list_sum_datapath_node_ram.sv | 35 +++
 rtl/list_sum_datapath.sv | 136 +++++++++++++
 4 files changed

// File: rtl/list_sum_datapath_pkg.sv
// Shared definitions for the linked-list summation unit (control FSM and datapath).
// Holds default widths, the node layout offsets and the read-select encoding.
package list_sum_defs;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 6;

    // A node occupies two consecutive words: value, then pointer.
    localparam int unsigned VALUE_OFS = 0;
    localparam int unsigned PTR_OFS   = 1;

    // Which word of the current node the datapath reads (ADDR_SEL encoding).
    typedef enum logic {
        RD_PTR   = 1'b0,
        RD_VALUE = 1'b1
    } rd_sel_e;

endpackage

// File: rtl/list_sum_datapath_if.sv
// Control bundle between the list-sum control FSM and its datapath.
//   master : the FSM, drives the registered controls and samples next_zero
//   slave  : the datapath, consumes the controls and returns next_zero
interface list_sum_datapath_if;

    logic LOAD_SUM;
    logic LOAD_NEXT;
    logic SUM_SEL;
    logic NEXT_SEL;
    logic ADDR_SEL;
    logic DONE;
    logic next_zero;

    modport master (
        output LOAD_SUM, LOAD_NEXT, SUM_SEL, NEXT_SEL, ADDR_SEL, DONE,
        input  next_zero
    );

    modport slave (
        input  LOAD_SUM, LOAD_NEXT, SUM_SEL, NEXT_SEL, ADDR_SEL, DONE,
        output next_zero
    );

endinterface

// File: rtl/list_sum_datapath_node_ram.sv
// Node memory: 2**ADDR_W x DATA_W, one synchronous write port and one
// combinational read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (mem[raddr], pre-write value on a same-address write)
module node_ram
    import list_sum_defs::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/list_sum_datapath.sv
// Datapath for the linked-list summation unit. Register-transfer slave of the
// list-sum control FSM: owns node memory, running sum, next pointer, host
// preload port and the latched result.
//   clk, rst     : clock, asynchronous active-low reset
//   ctrl         : FSM controls in, next_zero out
//   start_addr   : head-node address, loaded while NEXT_SEL=0
//   prog_we/addr/data : host write port, accepted only while idle
//   sum_out      : result latched on DONE rising
//   node_count   : nodes accumulated, saturates at 2**ADDR_W
//   result_valid : sum_out and flags valid
//   overflow     : sticky carry-out of the sum
//   loop_err     : sticky, node count reached 2**ADDR_W
//   prog_rej     : one-cycle pulse, a host write was dropped while busy
module list_sum_datapath
    import list_sum_defs::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    list_sum_datapath_if.slave    ctrl,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic                  prog_we,
    input  logic [ADDR_W-1:0]     prog_addr,
    input  logic [DATA_W-1:0]     prog_data,
    output logic [DATA_W-1:0]     sum_out,
    output logic [ADDR_W:0]       node_count,
    output logic                  result_valid,
    output logic                  overflow,
    output logic                  loop_err,
    output logic                  prog_rej
);

    localparam logic [ADDR_W:0] NODE_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] sum_reg;
    logic [ADDR_W-1:0] next_reg;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W:0]   sum_ext;
    logic              busy;
    logic              done_q;
    rd_sel_e           rd_sel;

    assign rd_sel = rd_sel_e'(ctrl.ADDR_SEL);

    // Address arithmetic wraps mod 2**ADDR_W, so head 2**ADDR_W-1 reads its
    // pointer at address 0.
    always_comb begin
        rd_addr = next_reg + ADDR_W'(PTR_OFS);
        if (rd_sel == RD_VALUE) begin
            rd_addr = next_reg + ADDR_W'(VALUE_OFS);
        end
    end

    assign busy    = ctrl.SUM_SEL | ctrl.NEXT_SEL;
    assign sum_ext = {1'b0, sum_reg} + {1'b0, rdata};

    assign ctrl.next_zero = (rd_sel == RD_PTR) && (rdata[ADDR_W-1:0] == '0);

    node_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_node_ram (
        .clk   (clk),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (rd_addr),
        .rdata (rdata)
    );

    // Running sum and its status. SUM_SEL=0 is a clear, independent of LOAD_SUM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_reg    <= '0;
            node_count <= '0;
            overflow   <= 1'b0;
            loop_err   <= 1'b0;
        end else if (!ctrl.SUM_SEL) begin
            sum_reg    <= '0;
            node_count <= '0;
            overflow   <= 1'b0;
            loop_err   <= 1'b0;
        end else if (ctrl.LOAD_SUM) begin
            sum_reg <= sum_ext[DATA_W-1:0];
            if (sum_ext[DATA_W]) begin
                overflow <= 1'b1;
            end
            if (node_count != NODE_MAX) begin
                node_count <= node_count + 1'b1;
                if (node_count == NODE_MAX - 1'b1) begin
                    loop_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            next_reg <= '0;
        end else if (!ctrl.NEXT_SEL) begin
            next_reg <= start_addr;
        end else if (ctrl.LOAD_NEXT) begin
            next_reg <= rdata[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prog_rej <= 1'b0;
        end else begin
            prog_rej <= prog_we && busy;
        end
    end

    // A DONE rising edge wins over the SUM_SEL clear, since the FSM may still
    // hold SUM_SEL=1 in its done state to keep sum_reg intact.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q       <= 1'b0;
            sum_out      <= '0;
            result_valid <= 1'b0;
        end else begin
            done_q <= ctrl.DONE;
            if (ctrl.DONE && !done_q) begin
                sum_out      <= sum_reg;
                result_valid <= 1'b1;
            end else if (ctrl.SUM_SEL) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule
